// File: rtl/cpu_sequencer_if.sv
// Instruction handshake and datapath control bundle between the sequencer
// (master) and the instruction source / regfile / ALU / DATA_MEM (slave).
interface cpu_sequencer_if #(
  parameter int INSTR_WIDTH   = 20,
  parameter int REG_ADDR_BITS = 2,
  parameter int IMM_BITS      = 8
);
  logic                     instr_valid;
  logic [INSTR_WIDTH-1:0]   instruction;
  logic                     instr_ready;
  logic                     mem_ready;
  logic [REG_ADDR_BITS-1:0] rd_addr_a;
  logic [REG_ADDR_BITS-1:0] rd_addr_b;
  logic [REG_ADDR_BITS-1:0] wr_addr;
  logic                     wr_en;
  logic                     wb_sel_mem;
  logic                     alu_op;
  logic                     alu_b_imm;
  logic [IMM_BITS-1:0]      imm;
  logic                     mem_rd_en;
  logic                     mem_wr_en;

  modport master (
    input  instr_valid, instruction, mem_ready,
    output instr_ready, rd_addr_a, rd_addr_b, wr_addr, wr_en, wb_sel_mem,
           alu_op, alu_b_imm, imm, mem_rd_en, mem_wr_en
  );

  modport slave (
    output instr_valid, instruction, mem_ready,
    input  instr_ready, rd_addr_a, rd_addr_b, wr_addr, wr_en, wb_sel_mem,
           alu_op, alu_b_imm, imm, mem_rd_en, mem_wr_en
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for simple_cpu. Latches one instruction per
// valid/ready handshake and sequences DECODE/EXEC/MEM/WB control strobes.
// Every output is a flop loaded from the next state and next IR, so outputs
// keep Moore timing and clear asynchronously with the reset.
module cpu_sequencer #(
  parameter int INSTR_WIDTH   = 20,
  parameter int REG_ADDR_BITS = 2,
  parameter int IMM_BITS      = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cpu_sequencer_if.master      bus,
  output logic                 busy_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] retired_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_RTYPE = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  state_e                   state_q, state_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
  logic                     illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]     retired_cnt_q, retired_cnt_d;
  logic                     fire_s;
  logic                     retire_s;

  // Registered control outputs and their next values
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic [REG_ADDR_BITS-1:0] rd_a_q, rd_a_d;
  logic [REG_ADDR_BITS-1:0] rd_b_q, rd_b_d;
  logic [REG_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic                     wr_en_q, wr_en_d;
  logic                     wb_sel_q, wb_sel_d;
  logic                     alu_op_q, alu_op_d;
  logic                     alu_b_imm_q, alu_b_imm_d;
  logic [IMM_BITS-1:0]      imm_q, imm_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;

  // Fields of the current IR (drive the state transitions)
  logic [1:0] op_s;
  logic       funct_bad_s;
  assign op_s        = ir_q[19:18];
  assign funct_bad_s = (ir_q[3:1] != 3'b000);

  // Fields of the next IR (drive the registered outputs)
  logic [1:0] n_op_s;
  logic [1:0] n_x1_s, n_x2_s, n_x3_s;
  assign n_op_s = ir_d[19:18];
  assign n_x1_s = ir_d[17:16];
  assign n_x2_s = ir_d[15:14];
  assign n_x3_s = ir_d[13:12];

  assign fire_s = bus.instr_valid & ready_q;

  // Next-state, IR load, sticky illegal flag and retire counting
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (fire_s) begin
          ir_d    = bus.instruction;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (op_s == OP_NOP) begin
          state_d = S_IDLE;
        end else if ((op_s == OP_RTYPE) && funct_bad_s) begin
          // Unsupported funct retires as a NOP and is remembered
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_s == OP_RTYPE) begin
          state_d = S_WB;
        end else if ((op_s == OP_LOAD) || (op_s == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = (op_s == OP_LOAD) ? S_WB : S_IDLE;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Any return to IDLE from a busy state completes an instruction
    retire_s      = (state_q != S_IDLE) && (state_d == S_IDLE);
    retired_cnt_d = retired_cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire_s};
  end

  // Decode the control strobes for the state being entered
  always_comb begin
    logic [REG_ADDR_BITS-1:0] rd_a_s, rd_b_s;
    logic                     alu_op_s, alu_b_imm_s;
    rd_a_s      = {REG_ADDR_BITS{1'b0}};
    rd_b_s      = {REG_ADDR_BITS{1'b0}};
    alu_op_s    = 1'b0;
    alu_b_imm_s = 1'b0;
    if (n_op_s != OP_NOP) begin
      rd_a_s = n_x2_s;
    end else begin
      rd_a_s = {REG_ADDR_BITS{1'b0}};
    end
    if (n_op_s == OP_RTYPE) begin
      rd_b_s   = n_x3_s;
      alu_op_s = ir_d[0];
    end else if (n_op_s == OP_STORE) begin
      rd_b_s      = n_x1_s;
      alu_b_imm_s = 1'b1;
    end else if (n_op_s == OP_LOAD) begin
      alu_b_imm_s = 1'b1;
    end else begin
      rd_b_s = {REG_ADDR_BITS{1'b0}};
    end

    ready_d     = 1'b0;
    busy_d      = 1'b1;
    rd_a_d      = {REG_ADDR_BITS{1'b0}};
    rd_b_d      = {REG_ADDR_BITS{1'b0}};
    wr_addr_d   = {REG_ADDR_BITS{1'b0}};
    wr_en_d     = 1'b0;
    wb_sel_d    = 1'b0;
    alu_op_d    = 1'b0;
    alu_b_imm_d = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    imm_d       = ir_d[11:4];
    case (state_d)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_DECODE: begin
        rd_a_d = rd_a_s;
        rd_b_d = rd_b_s;
      end
      S_EXEC: begin
        rd_a_d      = rd_a_s;
        rd_b_d      = rd_b_s;
        alu_op_d    = alu_op_s;
        alu_b_imm_d = alu_b_imm_s;
      end
      S_MEM: begin
        // Address and store data stay selected while the access stalls
        rd_a_d      = rd_a_s;
        rd_b_d      = rd_b_s;
        alu_op_d    = alu_op_s;
        alu_b_imm_d = alu_b_imm_s;
        mem_rd_d    = (n_op_s == OP_LOAD);
        mem_wr_d    = (n_op_s == OP_STORE);
      end
      S_WB: begin
        // ALU operands stay selected so the R-type result is still valid
        rd_a_d      = rd_a_s;
        rd_b_d      = rd_b_s;
        alu_op_d    = alu_op_s;
        alu_b_imm_d = alu_b_imm_s;
        wr_en_d     = 1'b1;
        wr_addr_d   = n_x1_s;
        wb_sel_d    = (n_op_s == OP_LOAD);
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, IR, flag, counter and output registers with async clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      ir_q          <= {INSTR_WIDTH{1'b0}};
      illegal_q     <= 1'b0;
      retired_cnt_q <= {CNT_WIDTH{1'b0}};
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      rd_a_q        <= {REG_ADDR_BITS{1'b0}};
      rd_b_q        <= {REG_ADDR_BITS{1'b0}};
      wr_addr_q     <= {REG_ADDR_BITS{1'b0}};
      wr_en_q       <= 1'b0;
      wb_sel_q      <= 1'b0;
      alu_op_q      <= 1'b0;
      alu_b_imm_q   <= 1'b0;
      imm_q         <= {IMM_BITS{1'b0}};
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      illegal_q     <= illegal_d;
      retired_cnt_q <= retired_cnt_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      rd_a_q        <= rd_a_d;
      rd_b_q        <= rd_b_d;
      wr_addr_q     <= wr_addr_d;
      wr_en_q       <= wr_en_d;
      wb_sel_q      <= wb_sel_d;
      alu_op_q      <= alu_op_d;
      alu_b_imm_q   <= alu_b_imm_d;
      imm_q         <= imm_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.rd_addr_a   = rd_a_q;
  assign bus.rd_addr_b   = rd_b_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wb_sel_mem  = wb_sel_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_b_imm   = alu_b_imm_q;
  assign bus.imm         = imm_q;
  assign bus.mem_rd_en   = mem_rd_q;
  assign bus.mem_wr_en   = mem_wr_q;
  assign busy_o          = busy_q;
  assign illegal_o       = illegal_q;
  assign retired_cnt_o   = retired_cnt_q;

endmodule
